// File: rtl/data_out_sel_pkg.sv
// Shared state encoding and parameter defaults for the channel-select output register.
package data_out_sel_pkg;

  localparam int unsigned NCH_DEF        = 4;
  localparam int unsigned DW_DEF         = 8;
  localparam int unsigned STABLE_CYC_DEF = 3;
  localparam int unsigned GUARD_CYC_DEF  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StGuard
  } sel_state_e;

endpackage

// File: rtl/en_qualifier.sv
// Debounces the one-hot channel request: sample register, saturating stability counter,
// one-hot check and binary encode of the qualified value.
module en_qualifier
  import data_out_sel_pkg::*;
#(
  parameter int unsigned NCH        = NCH_DEF,
  parameter int unsigned STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         en,
  output logic                   qual,
  output logic                   qual_valid,
  output logic [$clog2(NCH)-1:0] qual_idx,
  output logic                   en_multi
);

  localparam int unsigned IW = $clog2(NCH);
  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYC);

  logic [NCH-1:0] en_q;
  logic [3:0]     cnt_q;
  logic [4:0]     ones_q;
  logic [4:0]     ones_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q  <= '0;
      cnt_q <= '0;
    end else begin
      en_q <= en;
      // A changed sample is itself the first of a new run.
      if (en != en_q) begin
        cnt_q <= 4'd1;
      end else if (cnt_q != STABLE_MAX) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    ones_q   = '0;
    ones_en  = '0;
    qual_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      ones_q  = ones_q + 5'(en_q[i]);
      ones_en = ones_en + 5'(en[i]);
      if (en_q[i]) begin
        qual_idx = IW'(i);
      end
    end
  end

  assign qual       = (cnt_q == STABLE_MAX);
  assign qual_valid = qual && (ones_q == 5'd1);
  assign en_multi   = (ones_en > 5'd1);

endmodule

// File: rtl/data_out_sel_reg.sv
// Registered channel multiplexer with debounced one-hot select, a break-before-make
// guard interval on the output enable, and a sticky multi-hot error flag.
module data_out_sel_reg
  import data_out_sel_pkg::*;
#(
  parameter int unsigned NCH        = NCH_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned STABLE_CYC = STABLE_CYC_DEF,
  parameter int unsigned GUARD_CYC  = GUARD_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         en,
  input  logic [NCH*DW-1:0]      din,
  input  logic                   err_clr,
  output logic [DW-1:0]          dout,
  output logic                   dout_oe,
  output logic [$clog2(NCH)-1:0] sel_idx,
  output logic                   sel_err
);

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYC - 1);

  sel_state_e             state;
  logic [3:0]             guard_cnt;
  logic                   qual;
  logic                   qual_valid;
  logic [$clog2(NCH)-1:0] qual_idx;
  logic                   en_multi;
  logic [DW-1:0]          new_data;
  logic [DW-1:0]          cur_data;

  en_qualifier #(
    .NCH        (NCH),
    .STABLE_CYC (STABLE_CYC)
  ) u_en_qualifier (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .qual       (qual),
    .qual_valid (qual_valid),
    .qual_idx   (qual_idx),
    .en_multi   (en_multi)
  );

  assign new_data = din[int'(qual_idx) * DW +: DW];
  assign cur_data = din[int'(sel_idx) * DW +: DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      dout      <= '0;
      dout_oe   <= 1'b0;
      sel_idx   <= '0;
      guard_cnt <= '0;
      sel_err   <= 1'b0;
    end else begin
      // Set has priority over clear.
      sel_err <= en_multi | (sel_err & ~err_clr);
      unique case (state)
        StIdle: begin
          if (qual_valid) begin
            state   <= StActive;
            dout_oe <= 1'b1;
            sel_idx <= qual_idx;
            dout    <= new_data;
          end
        end
        StActive: begin
          // Re-qualifying the same channel falls through to the reload path.
          if (qual && (!qual_valid || (qual_idx != sel_idx))) begin
            state     <= StGuard;
            dout_oe   <= 1'b0;
            guard_cnt <= GUARD_LOAD;
          end else begin
            dout <= cur_data;
          end
        end
        StGuard: begin
          if (guard_cnt != 4'd0) begin
            guard_cnt <= guard_cnt - 4'd1;
          end else if (qual_valid) begin
            state   <= StActive;
            dout_oe <= 1'b1;
            sel_idx <= qual_idx;
            dout    <= new_data;
          end else begin
            state <= StIdle;
          end
        end
        default: begin
          state   <= StIdle;
          dout_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_out_sel_reg.sv
// Directed, table-driven bench for data_out_sel_reg at NCH=4, DW=8, STABLE_CYC=3, GUARD_CYC=2.
module tb_data_out_sel_reg;

  logic        clk;
  logic        rst;
  logic [3:0]  en;
  logic [31:0] din;
  logic        err_clr;
  logic [7:0]  dout;
  logic        dout_oe;
  logic [1:0]  sel_idx;
  logic        sel_err;

  int n_tests;
  int n_fail;

  localparam logic [31:0] D0 = {8'h5C, 8'h33, 8'hA5, 8'h11};
  localparam logic [31:0] D1 = {8'h5C, 8'h33, 8'h77, 8'h11};

  typedef struct {
    string       name;
    logic [3:0]  en;
    logic [31:0] din;
    logic        err_clr;
    logic        oe;
    logic [1:0]  idx;
    logic [7:0]  dout;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  data_out_sel_reg #(
    .NCH        (4),
    .DW         (8),
    .STABLE_CYC (3),
    .GUARD_CYC  (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .din     (din),
    .err_clr (err_clr),
    .dout    (dout),
    .dout_oe (dout_oe),
    .sel_idx (sel_idx),
    .sel_err (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic oe, input logic [1:0] idx,
                         input logic [7:0] d, input logic err);
    chk({name, ".oe"},   32'(dout_oe), 32'(oe));
    chk({name, ".idx"},  32'(sel_idx), 32'(idx));
    chk({name, ".dout"}, 32'(dout),    32'(d));
    chk({name, ".err"},  32'(sel_err), 32'(err));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input string nm, input logic [3:0] e, input logic [31:0] d,
                              input logic c, input logic oe, input logic [1:0] idx,
                              input logic [7:0] dv, input logic err);
    vec_t v;
    v.name = nm; v.en = e; v.din = d; v.err_clr = c;
    v.oe = oe; v.idx = idx; v.dout = dv; v.err = err;
    vecs.push_back(v);
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    en      = 4'b0000;
    din     = D0;
    err_clr = 1'b0;

    // Select ch1, latency to ACTIVE, then one-cycle data latency.
    add("q1",   4'b0010, D0, 0, 0, 0, 8'h00, 0);
    add("q2",   4'b0010, D0, 0, 0, 0, 8'h00, 0);
    add("q3",   4'b0010, D0, 0, 0, 0, 8'h00, 0);
    add("act1", 4'b0010, D0, 0, 1, 1, 8'hA5, 0);
    add("lat",  4'b0010, D1, 0, 1, 1, 8'h77, 0);
    // Short glitch to ch2 is ignored; re-qualifying ch1 causes no glitch.
    add("gl1",  4'b0100, D0, 0, 1, 1, 8'hA5, 0);
    add("gl2",  4'b0100, D0, 0, 1, 1, 8'hA5, 0);
    add("rq1",  4'b0010, D0, 0, 1, 1, 8'hA5, 0);
    add("rq2",  4'b0010, D0, 0, 1, 1, 8'hA5, 0);
    add("rq3",  4'b0010, D0, 0, 1, 1, 8'hA5, 0);
    add("rq4",  4'b0010, D0, 0, 1, 1, 8'hA5, 0);
    // Switch to ch3 through a 2-cycle guard; dout holds while din changes.
    add("sw1",  4'b1000, D0, 0, 1, 1, 8'hA5, 0);
    add("sw2",  4'b1000, D0, 0, 1, 1, 8'hA5, 0);
    add("sw3",  4'b1000, D0, 0, 1, 1, 8'hA5, 0);
    add("gd1",  4'b1000, D1, 0, 0, 1, 8'hA5, 0);
    add("gd2",  4'b1000, D1, 0, 0, 1, 8'hA5, 0);
    add("act3", 4'b1000, D0, 0, 1, 3, 8'h5C, 0);
    // Multi-hot: immediate sticky error, invalid qualify -> guard -> idle.
    add("mh1",  4'b0110, D0, 0, 1, 3, 8'h5C, 1);
    add("mh2",  4'b0110, D0, 0, 1, 3, 8'h5C, 1);
    add("mh3",  4'b0110, D0, 0, 1, 3, 8'h5C, 1);
    add("mhg1", 4'b0110, D0, 0, 0, 3, 8'h5C, 1);
    add("mhg2", 4'b0110, D0, 0, 0, 3, 8'h5C, 1);
    add("mhid", 4'b0110, D0, 0, 0, 3, 8'h5C, 1);
    add("setw", 4'b0110, D0, 1, 0, 3, 8'h5C, 1);
    add("clr",  4'b0000, D0, 1, 0, 3, 8'h5C, 0);
    add("idle", 4'b0000, D0, 0, 0, 3, 8'h5C, 0);

    step();
    step();
    chk_all("rst", 1'b0, 2'd0, 8'h00, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      en      = vecs[i].en;
      din     = vecs[i].din;
      err_clr = vecs[i].err_clr;
      step();
      chk_all(vecs[i].name, vecs[i].oe, vecs[i].idx, vecs[i].dout, vecs[i].err);
    end

    // Enter ACTIVE on ch0, then assert reset between edges.
    en      = 4'b0001;
    err_clr = 1'b0;
    repeat (4) step();
    chk_all("a0", 1'b1, 2'd0, 8'h11, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_all("arst", 1'b0, 2'd0, 8'h00, 1'b0);
    step();
    chk_all("rsth", 1'b0, 2'd0, 8'h00, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("rq%0d.oe", k), 32'(dout_oe), 32'd0);
    end
    step();
    chk_all("re4", 1'b1, 2'd0, 8'h11, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_out_sel_reg.md
DATA_OUT_SEL_REG -- requirements
Module: data_out_sel_reg

Interface
REQ-001 SHALL have parameter NCH, default 4: number of input channels, 2..16.
REQ-002 SHALL have parameter DW, default 8: data width per channel.
REQ-003 SHALL have parameter STABLE_CYC, default 3: consecutive identical en samples needed to qualify a select change, 1..15.
REQ-004 SHALL have parameter GUARD_CYC, default 2: output-disabled cycles between channels, 1..15.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port en, input, NCH: one-hot channel request; bit i selects channel i.
REQ-008 SHALL have port din, input, NCH*DW: packed channel data; channel i at din[i*DW +: DW].
REQ-009 SHALL have port err_clr, input, 1: clears sel_err.
REQ-010 SHALL have port dout, output, DW: registered selected data.
REQ-011 SHALL have port dout_oe, output, 1: output enable; the pad driver tristates dout when low.
REQ-012 SHALL have port sel_idx, output, clog2(NCH): binary index of the active channel.
REQ-013 SHALL have port sel_err, output, 1: sticky multi-hot select flag.

Function
REQ-014 SHALL sample en every edge; en is qualified once the same value has been sampled on STABLE_CYC consecutive edges; the qualified value is valid if exactly one bit is set, else invalid (zero or multi-hot).
REQ-015 SHALL implement states IDLE (dout_oe=0), ACTIVE (dout_oe=1), GUARD (dout_oe=0).
REQ-016 IDLE -> ACTIVE on the edge after a valid qualified en; sel_idx latches the encoded index and dout loads din[that channel] on the same edge.
REQ-017 ACTIVE: dout SHALL load din[sel_idx] every edge (one-cycle latency).
REQ-018 ACTIVE -> GUARD on the edge after a qualified en that is invalid or selects a channel other than sel_idx.
REQ-019 An en change shorter than STABLE_CYC samples SHALL be ignored; ACTIVE continues on the current channel.
REQ-020 GUARD SHALL last exactly GUARD_CYC cycles; dout holds its last value; sel_idx holds.
REQ-021 At the end of GUARD: valid qualified en -> ACTIVE with that channel (latch sel_idx, load dout); otherwise -> IDLE; en changes during GUARD are evaluated only at that point.
REQ-022 sel_err SHALL set on any edge where sampled en has two or more bits set, qualified or not; cleared by err_clr; set wins on a simultaneous set and clear.
REQ-023 Re-qualifying the current channel in ACTIVE SHALL cause no transition and no dout_oe glitch.

Reset
REQ-024 While rst is high: state IDLE, dout=0, dout_oe=0, sel_idx=0, sel_err=0, stability counter and en sample register 0.
REQ-025 rst asserted mid-ACTIVE or mid-GUARD SHALL drop dout_oe immediately (asynchronously); after release, qualification restarts from zero.

Structure
REQ-026 State enumeration and parameter defaults SHALL live in a shared package data_out_sel_pkg.
REQ-027 Select qualification (sample register, saturating stability counter, one-hot check, binary encoder) SHALL be sub-module en_qualifier; the FSM and data register stay in data_out_sel_reg.

Verification (NCH=4, DW=8, STABLE_CYC=3, GUARD_CYC=2)
REQ-028 en=4'b0010 applied before edge 1 and held, din ch1=8'hA5 -> dout_oe=1, sel_idx=1, dout=8'hA5 after edge 4.
REQ-029 ACTIVE on ch1; en=4'b1000 held -> dout_oe=0 after edge 4, stays low 2 cycles, dout_oe=1 with sel_idx=3 after edge 6.
REQ-030 ACTIVE on ch1; en pulses 4'b0100 for 2 cycles, then returns to 4'b0010 -> no state change, dout_oe stays 1, sel_idx=1.
REQ-031 en=4'b0110 held -> sel_err=1 after edge 1; FSM stays IDLE (or enters GUARD then IDLE from ACTIVE); err_clr pulse with en=0 clears sel_err; err_clr together with multi-hot en leaves sel_err=1.
REQ-032 rst pulsed mid-ACTIVE between edges -> dout_oe=0 and dout=0 without waiting for an edge; after release, held en=4'b0001 re-enters ACTIVE on the 4th edge.
